// File: rtl/proc_phase_sequencer.sv
// Multi-cycle processor phase sequencer: fetch/decode/exe/mem/wb with a memory
// handshake, wait-state timeout, optional MEM skipping, halt/resume, PC and counters.
module proc_phase_sequencer #(
    parameter int unsigned ADDR_WIDTH   = 26,
    parameter int unsigned RESET_PC     = 'h1000,
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned SKIP_MEM     = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IS_MEM_OP,
    input  logic                  IS_STORE,
    input  logic                  PC_LOAD,
    input  logic [ADDR_WIDTH-1:0] PC_TARGET,
    input  logic [ADDR_WIDTH-1:0] MEM_ADDR_IN,
    input  logic                  MEM_ACK,
    input  logic                  HALT_REQ,
    input  logic                  RESUME,
    output logic [2:0]            STATE,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic                  MEM_REQ,
    output logic                  MEM_RD,
    output logic                  MEM_WR,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic                  HALTED,
    output logic                  TIMEOUT,
    output logic [CNT_WIDTH-1:0]  CYCLE_CNT,
    output logic [CNT_WIDTH-1:0]  INST_CNT
);

    localparam int unsigned WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXE    = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5,
        ERR    = 3'd6,
        IDLE   = 3'd7
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WAIT_W-1:0]     r_wait;
    logic [WAIT_W-1:0]     w_wait_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic [ADDR_WIDTH-1:0] r_addr_lat;
    logic [ADDR_WIDTH-1:0] w_addr_lat_nxt;
    logic                  r_memop;
    logic                  w_memop_nxt;
    logic                  r_store;
    logic                  w_store_nxt;
    logic                  r_timeout;
    logic [CNT_WIDTH-1:0]  r_cycle_cnt;
    logic [CNT_WIDTH-1:0]  r_inst_cnt;
    logic                  r_mem_req;
    logic                  r_mem_rd;
    logic                  r_mem_wr;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_halted;
    logic                  w_mem_req_nxt;
    logic                  w_mem_rd_nxt;
    logic                  w_mem_wr_nxt;
    logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
    logic                  w_halted_nxt;
    logic                  w_wait_hit;
    logic                  w_active;

    // The limit is hit on the edge that would bring the wait count up to MEM_WAIT_MAX.
    assign w_wait_hit = (MEM_WAIT_MAX != 0) && (r_wait == WAIT_W'(MEM_WAIT_MAX - 1));
    assign w_active   = (r_state != IDLE) && (r_state != ERR);

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        case (r_state)
            IDLE:   w_state_nxt = FETCH;
            FETCH, MEM: begin
                if ((r_state == MEM) && !r_memop) begin
                    w_state_nxt = WB;
                end else if (MEM_ACK) begin
                    w_state_nxt = (r_state == FETCH) ? DECODE : WB;
                    w_wait_nxt  = '0;
                end else if (w_wait_hit) begin
                    w_state_nxt = ERR;
                end else if (MEM_WAIT_MAX != 0) begin
                    w_wait_nxt = r_wait + WAIT_W'(1);
                end
            end
            DECODE: w_state_nxt = EXE;
            EXE:    w_state_nxt = (IS_MEM_OP || (SKIP_MEM == 0)) ? MEM : WB;
            WB:     w_state_nxt = HALT_REQ ? HALT : FETCH;
            HALT:   w_state_nxt = RESUME ? FETCH : HALT;
            ERR:    w_state_nxt = ERR;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the datapath-side registers
    always_comb begin
        w_memop_nxt    = r_memop;
        w_store_nxt    = r_store;
        w_addr_lat_nxt = r_addr_lat;
        w_pc_nxt       = r_pc;
        if (r_state == EXE) begin
            w_memop_nxt    = IS_MEM_OP;
            w_store_nxt    = IS_STORE;
            w_addr_lat_nxt = MEM_ADDR_IN;
        end
        if (r_state == WB) begin
            w_pc_nxt = PC_LOAD ? PC_TARGET : (r_pc + ADDR_WIDTH'(1));
        end
    end

    // Output decode, evaluated on the next state so the strobes come straight from flops
    always_comb begin
        w_mem_req_nxt  = 1'b0;
        w_mem_rd_nxt   = 1'b0;
        w_mem_wr_nxt   = 1'b0;
        w_mem_addr_nxt = w_pc_nxt;
        w_halted_nxt   = 1'b0;
        case (w_state_nxt)
            FETCH: begin
                w_mem_req_nxt = 1'b1;
                w_mem_rd_nxt  = 1'b1;
            end
            MEM: begin
                if (w_memop_nxt) begin
                    w_mem_req_nxt  = 1'b1;
                    w_mem_wr_nxt   = w_store_nxt;
                    w_mem_rd_nxt   = !w_store_nxt;
                    w_mem_addr_nxt = w_addr_lat_nxt;
                end
            end
            HALT:    w_halted_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_pc        <= ADDR_WIDTH'(RESET_PC);
            r_addr_lat  <= '0;
            r_memop     <= 1'b0;
            r_store     <= 1'b0;
            r_timeout   <= 1'b0;
            r_cycle_cnt <= '0;
            r_inst_cnt  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= ADDR_WIDTH'(RESET_PC);
            r_halted    <= 1'b0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_addr_lat <= w_addr_lat_nxt;
            r_memop    <= w_memop_nxt;
            r_store    <= w_store_nxt;
            r_mem_req  <= w_mem_req_nxt;
            r_mem_rd   <= w_mem_rd_nxt;
            r_mem_wr   <= w_mem_wr_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_halted   <= w_halted_nxt;
            if (w_state_nxt == ERR) begin
                r_timeout <= 1'b1;
            end
            if (w_active && (r_cycle_cnt != '1)) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_WIDTH'(1);
            end
            if (r_state == WB) begin
                r_inst_cnt <= r_inst_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign STATE     = r_state;
    assign PC        = r_pc;
    assign MEM_REQ   = r_mem_req;
    assign MEM_RD    = r_mem_rd;
    assign MEM_WR    = r_mem_wr;
    assign MEM_ADDR  = r_mem_addr;
    assign HALTED    = r_halted;
    assign TIMEOUT   = r_timeout;
    assign CYCLE_CNT = r_cycle_cnt;
    assign INST_CNT  = r_inst_cnt;

endmodule

// File: tb/tb_proc_phase_sequencer.sv
// Bench for proc_phase_sequencer: two instances (MEM skipping on/off) driven by shared
// directed stimulus, checked each cycle against a phase-level model plus literal pins.
module tb_proc_phase_sequencer;

    localparam int unsigned AW = 26;
    localparam int unsigned CW = 32;
    localparam int P_FETCH = 0, P_DECODE = 1, P_EXE = 2, P_MEM = 3, P_WB = 4,
                   P_HALT = 5, P_ERR = 6, P_IDLE = 7;
    localparam int WAIT_MAX = 15;
    localparam longint CNT_ALL1 = 64'h0000_0000_FFFF_FFFF;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          IS_MEM_OP = 1'b0;
    logic          IS_STORE = 1'b0;
    logic          PC_LOAD = 1'b0;
    logic [AW-1:0] PC_TARGET = '0;
    logic [AW-1:0] MEM_ADDR_IN = '0;
    logic          MEM_ACK = 1'b0;
    logic          HALT_REQ = 1'b0;
    logic          RESUME = 1'b0;

    logic [2:0]    st[2];
    logic [AW-1:0] pc[2];
    logic [AW-1:0] maddr[2];
    logic          req[2];
    logic          rd[2];
    logic          wr[2];
    logic          hl[2];
    logic          tmo[2];
    logic [CW-1:0] cyc[2];
    logic [CW-1:0] ic[2];

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    proc_phase_sequencer #(.SKIP_MEM(1)) u_dut0 (
        .CLK(CLK), .RST(RST), .IS_MEM_OP(IS_MEM_OP), .IS_STORE(IS_STORE),
        .PC_LOAD(PC_LOAD), .PC_TARGET(PC_TARGET), .MEM_ADDR_IN(MEM_ADDR_IN),
        .MEM_ACK(MEM_ACK), .HALT_REQ(HALT_REQ), .RESUME(RESUME),
        .STATE(st[0]), .PC(pc[0]), .MEM_REQ(req[0]), .MEM_RD(rd[0]), .MEM_WR(wr[0]),
        .MEM_ADDR(maddr[0]), .HALTED(hl[0]), .TIMEOUT(tmo[0]),
        .CYCLE_CNT(cyc[0]), .INST_CNT(ic[0])
    );

    proc_phase_sequencer #(.SKIP_MEM(0)) u_dut1 (
        .CLK(CLK), .RST(RST), .IS_MEM_OP(IS_MEM_OP), .IS_STORE(IS_STORE),
        .PC_LOAD(PC_LOAD), .PC_TARGET(PC_TARGET), .MEM_ADDR_IN(MEM_ADDR_IN),
        .MEM_ACK(MEM_ACK), .HALT_REQ(HALT_REQ), .RESUME(RESUME),
        .STATE(st[1]), .PC(pc[1]), .MEM_REQ(req[1]), .MEM_RD(rd[1]), .MEM_WR(wr[1]),
        .MEM_ADDR(maddr[1]), .HALTED(hl[1]), .TIMEOUT(tmo[1]),
        .CYCLE_CNT(cyc[1]), .INST_CNT(ic[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Phase-level model: one entry per instance, index 1 visits MEM on every instruction
    int            m_ph[2];
    int            m_wait[2];
    logic [AW-1:0] m_pc[2];
    logic [AW-1:0] m_addr[2];
    bit            m_memop[2];
    bit            m_store[2];
    bit            m_tmo[2];
    longint        m_cyc[2];
    longint        m_ic[2];

    task automatic model_reset(input int i);
        m_ph[i] = P_IDLE; m_wait[i] = 0; m_pc[i] = AW'(32'h1000); m_addr[i] = '0;
        m_memop[i] = 0; m_store[i] = 0; m_tmo[i] = 0; m_cyc[i] = 0; m_ic[i] = 0;
    endtask

    task automatic model_step(input int i);
        bit skip;
        skip = (i == 0);
        if (m_ph[i] != P_IDLE && m_ph[i] != P_ERR && m_cyc[i] != CNT_ALL1) m_cyc[i]++;
        case (m_ph[i])
            P_IDLE:   m_ph[i] = P_FETCH;
            P_DECODE: m_ph[i] = P_EXE;
            P_EXE: begin
                m_memop[i] = IS_MEM_OP; m_store[i] = IS_STORE; m_addr[i] = MEM_ADDR_IN;
                m_ph[i] = (IS_MEM_OP || !skip) ? P_MEM : P_WB;
            end
            P_FETCH, P_MEM: begin
                if (m_ph[i] == P_MEM && !m_memop[i]) m_ph[i] = P_WB;
                else if (MEM_ACK) begin
                    m_ph[i] = (m_ph[i] == P_FETCH) ? P_DECODE : P_WB;
                    m_wait[i] = 0;
                end else begin
                    m_wait[i]++;
                    if (m_wait[i] == WAIT_MAX) begin
                        m_ph[i] = P_ERR; m_tmo[i] = 1;
                    end
                end
            end
            P_WB: begin
                m_pc[i] = PC_LOAD ? PC_TARGET : m_pc[i] + AW'(1);
                m_ic[i] = (m_ic[i] + 1) & CNT_ALL1;
                m_ph[i] = HALT_REQ ? P_HALT : P_FETCH;
            end
            P_HALT:  if (RESUME) m_ph[i] = P_FETCH;
            default: ;
        endcase
    endtask

    always @(posedge CLK or negedge RST) begin
        for (int i = 0; i < 2; i++) begin
            if (!RST) model_reset(i);
            else model_step(i);
        end
    end

    // Every cycle out of reset, compare both instances with the model
    always @(posedge CLK) begin
        #1;
        if (RST === 1'b1) begin
            for (int i = 0; i < 2; i++) begin
                bit e_req, e_rd, e_wr;
                e_req = (m_ph[i] == P_FETCH) || (m_ph[i] == P_MEM && m_memop[i]);
                e_wr  = (m_ph[i] == P_MEM) && m_memop[i] && m_store[i];
                e_rd  = e_req && !e_wr;
                chk($sformatf("cmp%0d_state", i), 64'(st[i]), 64'(m_ph[i]));
                chk($sformatf("cmp%0d_pc", i), 64'(pc[i]), 64'(m_pc[i]));
                chk($sformatf("cmp%0d_req", i), 64'(req[i]), 64'(e_req));
                chk($sformatf("cmp%0d_rd", i), 64'(rd[i]), 64'(e_rd));
                chk($sformatf("cmp%0d_wr", i), 64'(wr[i]), 64'(e_wr));
                if (e_req)
                    chk($sformatf("cmp%0d_addr", i), 64'(maddr[i]),
                        64'((m_ph[i] == P_FETCH) ? m_pc[i] : m_addr[i]));
                chk($sformatf("cmp%0d_halted", i), 64'(hl[i]), 64'(m_ph[i] == P_HALT));
                chk($sformatf("cmp%0d_timeout", i), 64'(tmo[i]), 64'(m_tmo[i]));
                chk($sformatf("cmp%0d_cyc", i), 64'(cyc[i]), 64'(m_cyc[i]));
                chk($sformatf("cmp%0d_inst", i), 64'(ic[i]), 64'(m_ic[i]));
            end
        end
    end

    task automatic do_reset();
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge CLK);
    endtask

    int exp_seq[5];

    initial begin
        exp_seq = '{0, 1, 2, 4, 0};
        clks(2);
        chk("rst_state", 64'(st[0]), 64'd7);
        chk("rst_pc", 64'(pc[0]), 64'h1000);
        chk("rst_cyc", 64'(cyc[0]), 64'd0);
        chk("rst_inst", 64'(ic[0]), 64'd0);
        chk("rst_tmo", 64'(tmo[0]), 64'd0);
        chk("rst_halted", 64'(hl[0]), 64'd0);
        chk("rst_req", 64'(req[0]), 64'd0);

        // Zero wait states, no memory ops
        MEM_ACK = 1'b1;
        RST = 1'b1;
        for (int k = 0; k < 5; k++) begin
            clks(1);
            chk($sformatf("seq_state%0d", k), 64'(st[0]), 64'(exp_seq[k]));
            if (k == 3) begin
                chk("nskip_mem_state", 64'(st[1]), 64'd3);
                chk("nskip_mem_req", 64'(req[1]), 64'd0);
                chk("nskip_mem_rd", 64'(rd[1]), 64'd0);
                chk("nskip_mem_wr", 64'(wr[1]), 64'd0);
            end
        end
        chk("seq_pc", 64'(pc[0]), 64'h1001);
        chk("seq_inst", 64'(ic[0]), 64'd1);
        chk("seq_cyc", 64'(cyc[0]), 64'd4);
        clks(1);
        chk("nskip_state", 64'(st[1]), 64'd0);
        chk("nskip_inst", 64'(ic[1]), 64'd1);
        chk("nskip_cyc", 64'(cyc[1]), 64'd5);
        chk("nskip_pc", 64'(pc[1]), 64'h1001);

        // Fetch with 3 wait states, then a store with 2 wait states
        MEM_ACK = 1'b0;
        do_reset();
        clks(1);
        chk("f_state", 64'(st[0]), 64'd0);
        chk("f_req", 64'(req[0]), 64'd1);
        chk("f_rd", 64'(rd[0]), 64'd1);
        chk("f_wr", 64'(wr[0]), 64'd0);
        chk("f_addr", 64'(maddr[0]), 64'h1000);
        clks(3);
        chk("f_wait_state", 64'(st[0]), 64'd0);
        MEM_ACK = 1'b1;
        clks(1);
        chk("f_done_state", 64'(st[0]), 64'd1);
        MEM_ACK = 1'b0; IS_MEM_OP = 1'b1; IS_STORE = 1'b1; MEM_ADDR_IN = AW'(32'h20);
        clks(1);
        chk("st_exe", 64'(st[0]), 64'd2);
        clks(1);
        chk("st_mem", 64'(st[0]), 64'd3);
        chk("st_wr", 64'(wr[0]), 64'd1);
        chk("st_rd", 64'(rd[0]), 64'd0);
        chk("st_addr", 64'(maddr[0]), 64'h20);
        clks(2);
        chk("st_wait_state", 64'(st[0]), 64'd3);
        MEM_ACK = 1'b1;
        clks(1);
        chk("st_wb", 64'(st[0]), 64'd4);
        chk("st_cyc", 64'(cyc[0]), 64'd9);
        IS_MEM_OP = 1'b0; IS_STORE = 1'b0;

        // Timeout in FETCH
        MEM_ACK = 1'b0;
        do_reset();
        clks(15);
        chk("to_before", 64'(st[0]), 64'd0);
        clks(1);
        chk("to_state", 64'(st[0]), 64'd6);
        chk("to_flag", 64'(tmo[0]), 64'd1);
        chk("to_cyc", 64'(cyc[0]), 64'd15);
        MEM_ACK = 1'b1;
        clks(3);
        chk("to_stuck", 64'(st[0]), 64'd6);
        chk("to_cyc_frozen", 64'(cyc[0]), 64'd15);
        chk("to_sticky", 64'(tmo[0]), 64'd1);
        RST = 1'b0;
        #1;
        chk("to_clr_state", 64'(st[0]), 64'd7);
        chk("to_clr_flag", 64'(tmo[0]), 64'd0);

        // Branch plus halt in the same WB, then resume and PC wrap
        do_reset();
        clks(4);
        chk("h_wb", 64'(st[0]), 64'd4);
        PC_LOAD = 1'b1; PC_TARGET = AW'(32'h3FF_FFFF); HALT_REQ = 1'b1;
        clks(1);
        chk("h_state", 64'(st[0]), 64'd5);
        chk("h_pc", 64'(pc[0]), 64'h3FF_FFFF);
        chk("h_halted", 64'(hl[0]), 64'd1);
        chk("h_req", 64'(req[0]), 64'd0);
        clks(1);
        PC_LOAD = 1'b0; HALT_REQ = 1'b0;
        chk("h1_state", 64'(st[1]), 64'd5);
        chk("h1_pc", 64'(pc[1]), 64'h3FF_FFFF);
        clks(1);
        chk("h_hold", 64'(st[0]), 64'd5);
        RESUME = 1'b1;
        clks(1);
        RESUME = 1'b0;
        chk("r_state", 64'(st[0]), 64'd0);
        chk("r_halted", 64'(hl[0]), 64'd0);
        HALT_REQ = 1'b1;
        clks(2);
        HALT_REQ = 1'b0;
        clks(2);
        chk("wrap_state", 64'(st[0]), 64'd0);
        chk("wrap_pc", 64'(pc[0]), 64'h0);
        chk("wrap_inst", 64'(ic[0]), 64'd2);

        // Asynchronous reset in the middle of a fetch wait
        MEM_ACK = 1'b0;
        do_reset();
        clks(3);
        chk("ar_req_before", 64'(req[0]), 64'd1);
        RST = 1'b0;
        #1;
        chk("ar_req", 64'(req[0]), 64'd0);
        chk("ar_rd", 64'(rd[0]), 64'd0);
        chk("ar_state", 64'(st[0]), 64'd7);
        chk("ar_pc", 64'(pc[0]), 64'h1000);
        chk("ar_cyc", 64'(cyc[0]), 64'd0);
        chk("ar_inst", 64'(ic[0]), 64'd0);
        chk("ar1_req", 64'(req[1]), 64'd0);
        chk("ar1_cyc", 64'(cyc[1]), 64'd0);

        clks(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
